branch_resolve_queue: RTL and testbench

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/branch_resolve_queue.sv | 158 +++++++++++++++
 tb/tb_branch_resolve_queue.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue
//   Tracks predicted branches in fetch order and resolves them in order
//   against execute-stage outcomes. Each accepted resolve produces a
//   one-cycle predictor training pulse; a wrong prediction additionally
//   produces a one-cycle fetch redirect and discards every younger entry.
//
// Parameters
//   DEPTH              number of in-flight entries (power of two, >= 2)
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   enq_valid_i        fetch presents a predicted branch
//   enq_pc_i           branch PC
//   enq_pred_taken_i   predicted direction
//   enq_pred_target_i  predicted target
//   enq_ready_o        queue not full (accept = enq_valid_i & enq_ready_o)
//   res_valid_i        execute resolves the oldest branch
//   res_taken_i        actual direction
//   res_target_i       actual target
//   flush_i            pipeline flush, empties the queue, highest priority
//   upd_valid_o        training pulse, one cycle after an accepted resolve
//   upd_pc_o           PC of the resolved branch
//   upd_taken_o        actual direction of the resolved branch
//   mispredict_o       redirect pulse, one cycle after a wrong prediction
//   redirect_pc_o      correct fetch address (target, or PC + 4)
//   count_o            current occupancy
//   err_underflow_o    sticky: resolve seen while empty (cleared by reset)
//
// Optional feature (macro BRQ_STATS_EN)
//   stat_branches_o    saturating count of accepted resolves
//   stat_mispredicts_o saturating count of mispredicting resolves
// ---------------------------------------------------------------------------
module branch_resolve_queue #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enq_valid_i,
   input  logic [31:0]              enq_pc_i,
   input  logic                     enq_pred_taken_i,
   input  logic [31:0]              enq_pred_target_i,
   output logic                     enq_ready_o,
   input  logic                     res_valid_i,
   input  logic                     res_taken_i,
   input  logic [31:0]              res_target_i,
   input  logic                     flush_i,
   output logic                     upd_valid_o,
   output logic [31:0]              upd_pc_o,
   output logic                     upd_taken_o,
   output logic                     mispredict_o,
   output logic [31:0]              redirect_pc_o,
   output logic [$clog2(DEPTH):0]   count_o,
`ifdef BRQ_STATS_EN
   output logic                     err_underflow_o,
   output logic [31:0]              stat_branches_o,
   output logic [31:0]              stat_mispredicts_o
`else
   output logic                     err_underflow_o
`endif
);

   localparam int AW = $clog2(DEPTH);

   // Entry payload; no reset needed, validity is carried by the pointers.
   logic [31:0]   pc_mem     [DEPTH];
   logic          taken_mem  [DEPTH];
   logic [31:0]   target_mem [DEPTH];

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;

   logic          full;
   logic          empty;
   logic [31:0]   head_pc;
   logic          head_taken;
   logic [31:0]   head_target;
   logic          res_fire;
   logic          mispredict;
   logic          enq_fire;

   always_comb begin
      full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
      empty       = (wr_ptr == rd_ptr);
      enq_ready_o = !full;
      count_o     = wr_ptr - rd_ptr;

      head_pc     = pc_mem[rd_ptr[AW-1:0]];
      head_taken  = taken_mem[rd_ptr[AW-1:0]];
      head_target = target_mem[rd_ptr[AW-1:0]];

      // Flush outranks everything, so a resolve under flush is not a resolve.
      res_fire    = res_valid_i && !empty && !flush_i;
      mispredict  = res_fire &&
                    ((head_taken != res_taken_i) ||
                     (head_taken && res_taken_i && (head_target != res_target_i)));
      // Full is judged on registered state only: a same-cycle pop never
      // makes room for a push. Flush and mispredict drop the push.
      enq_fire    = enq_valid_i && !full && !flush_i && !mispredict;
   end

   always_ff @(posedge clk) begin
      if (enq_fire) begin
         pc_mem[wr_ptr[AW-1:0]]     <= enq_pc_i;
         taken_mem[wr_ptr[AW-1:0]]  <= enq_pred_taken_i;
         target_mem[wr_ptr[AW-1:0]] <= enq_pred_target_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         upd_valid_o     <= 1'b0;
         upd_pc_o        <= '0;
         upd_taken_o     <= 1'b0;
         mispredict_o    <= 1'b0;
         redirect_pc_o   <= '0;
         err_underflow_o <= 1'b0;
      end else begin
         // Emptying is done by catching the read pointer up to the write
         // pointer, which keeps both pointers on their modulo-2*DEPTH path.
         if (flush_i || mispredict) begin
            rd_ptr <= wr_ptr;
         end else begin
            if (res_fire) rd_ptr <= rd_ptr + 1'b1;
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
         end

         upd_valid_o  <= res_fire;
         mispredict_o <= mispredict;
         if (res_fire) begin
            upd_pc_o    <= head_pc;
            upd_taken_o <= res_taken_i;
         end
         if (mispredict) begin
            redirect_pc_o <= res_taken_i ? res_target_i : head_pc + 32'd4;
         end

         if (res_valid_i && empty && !flush_i) err_underflow_o <= 1'b1;
      end
   end

`ifdef BRQ_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches_o    <= '0;
         stat_mispredicts_o <= '0;
      end else begin
         if (res_fire && (stat_branches_o != '1))
            stat_branches_o <= stat_branches_o + 32'd1;
         if (mispredict && (stat_mispredicts_o != '1))
            stat_mispredicts_o <= stat_mispredicts_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_queue
//   Directed scenarios with literal expectations followed by randomized
//   traffic, all checked against a queue-based reference model.
//   Define BRQ_STATS_EN to also check the statistics counters.
// ---------------------------------------------------------------------------
module tb_branch_resolve_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enq_valid;
   logic [31:0] enq_pc;
   logic        enq_pred_taken;
   logic [31:0] enq_pred_target;
   logic        enq_ready;
   logic        res_valid;
   logic        res_taken;
   logic [31:0] res_target;
   logic        flush;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [3:0]  count;
   logic        err_underflow;
`ifdef BRQ_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   branch_resolve_queue #(.DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .enq_valid_i       (enq_valid),
      .enq_pc_i          (enq_pc),
      .enq_pred_taken_i  (enq_pred_taken),
      .enq_pred_target_i (enq_pred_target),
      .enq_ready_o       (enq_ready),
      .res_valid_i       (res_valid),
      .res_taken_i       (res_taken),
      .res_target_i      (res_target),
      .flush_i           (flush),
      .upd_valid_o       (upd_valid),
      .upd_pc_o          (upd_pc),
      .upd_taken_o       (upd_taken),
      .mispredict_o      (mispredict),
      .redirect_pc_o     (redirect_pc),
      .count_o           (count),
`ifdef BRQ_STATS_EN
      .err_underflow_o   (err_underflow),
      .stat_branches_o   (stat_branches),
      .stat_mispredicts_o(stat_mispredicts)
`else
      .err_underflow_o   (err_underflow)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } entry_t;

   entry_t      q[$];
   logic        m_upd_valid, m_upd_taken, m_mis, m_err;
   logic [31:0] m_upd_pc, m_redirect;
   logic [31:0] m_stat_br, m_stat_mis;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_upd_valid = 0; m_upd_taken = 0; m_mis = 0; m_err = 0;
      m_upd_pc = 0; m_redirect = 0; m_stat_br = 0; m_stat_mis = 0;
   endtask

   task automatic model_step();
      bit     was_empty, was_full, acc, mis;
      entry_t h, e;
      was_empty = (q.size() == 0);
      was_full  = (q.size() == DEPTH);
      acc       = res_valid && !was_empty && !flush;
      mis       = 0;
      if (acc) begin
         h   = q[0];
         mis = (h.taken != res_taken) || (h.taken && res_taken && h.target != res_target);
      end
      m_upd_valid = acc;
      m_mis       = mis;
      if (acc) begin
         m_upd_pc    = h.pc;
         m_upd_taken = res_taken;
         if (m_stat_br != 32'hFFFF_FFFF) m_stat_br++;
      end
      if (mis) begin
         m_redirect = res_taken ? res_target : h.pc + 32'd4;
         if (m_stat_mis != 32'hFFFF_FFFF) m_stat_mis++;
      end
      if (res_valid && was_empty && !flush) m_err = 1;
      if (flush || mis) begin
         q.delete();
      end else begin
         if (acc) void'(q.pop_front());
         if (enq_valid && !was_full) begin
            e.pc = enq_pc; e.taken = enq_pred_taken; e.target = enq_pred_target;
            q.push_back(e);
         end
      end
   endtask

   // Compare all outputs against the model (called #1 after each edge).
   task automatic compare();
      check("count", 32'(count), 32'(q.size()));
      check("enq_ready", 32'(enq_ready), 32'(q.size() < DEPTH));
      check("upd_valid", 32'(upd_valid), 32'(m_upd_valid));
      if (m_upd_valid) begin
         check("upd_pc", upd_pc, m_upd_pc);
         check("upd_taken", 32'(upd_taken), 32'(m_upd_taken));
      end
      check("mispredict", 32'(mispredict), 32'(m_mis));
      if (m_mis) check("redirect_pc", redirect_pc, m_redirect);
      check("err_underflow", 32'(err_underflow), 32'(m_err));
`ifdef BRQ_STATS_EN
      check("stat_branches", stat_branches, m_stat_br);
      check("stat_mispredicts", stat_mispredicts, m_stat_mis);
`endif
   endtask

   task automatic step(input bit ev, input logic [31:0] pc, input bit pt, input logic [31:0] ptg,
                       input bit rv, input bit rt, input logic [31:0] rtg, input bit fl);
      enq_valid = ev; enq_pc = pc; enq_pred_taken = pt; enq_pred_target = ptg;
      res_valid = rv; res_taken = rt; res_target = rtg; flush = fl;
      model_step();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n = 0;
      #3;
      model_reset();
      check("rst_count", 32'(count), 32'd0);
      check("rst_ready", 32'(enq_ready), 32'd1);
      check("rst_upd_valid", 32'(upd_valid), 32'd0);
      check("rst_upd_pc", upd_pc, 32'd0);
      check("rst_upd_taken", 32'(upd_taken), 32'd0);
      check("rst_mispredict", 32'(mispredict), 32'd0);
      check("rst_redirect", redirect_pc, 32'd0);
      check("rst_err", 32'(err_underflow), 32'd0);
`ifdef BRQ_STATS_EN
      check("rst_stat_br", stat_branches, 32'd0);
      check("rst_stat_mis", stat_mispredicts, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   initial begin
      logic [31:0] exp_pc;
`ifdef BRQ_STATS_EN
      logic [31:0] sb, sm;
`endif
      enq_valid = 0; enq_pc = 0; enq_pred_taken = 0; enq_pred_target = 0;
      res_valid = 0; res_taken = 0; res_target = 0; flush = 0;
      rst_n = 0;
      @(posedge clk);
      #1;
      do_reset();

      // Correct taken prediction trains the predictor without redirect.
      step(1, 32'h100, 1, 32'h200, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 32'h200, 0);
      check("d1_upd_valid", 32'(upd_valid), 32'd1);
      check("d1_upd_pc", upd_pc, 32'h100);
      check("d1_upd_taken", 32'(upd_taken), 32'd1);
      check("d1_mispredict", 32'(mispredict), 32'd0);

      // Direction mispredict flushes the younger entries.
      step(1, 32'h10, 0, 32'h0, 0, 0, 0, 0);
      step(1, 32'h14, 0, 32'h0, 0, 0, 0, 0);
      step(1, 32'h18, 0, 32'h0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 32'h40, 0);
      check("d2_mispredict", 32'(mispredict), 32'd1);
      check("d2_redirect", redirect_pc, 32'h40);
      check("d2_count", 32'(count), 32'd0);

      // Not-taken actual against taken prediction: redirect to PC+4.
      step(1, 32'hFFFF_FFFC, 1, 32'h80, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 32'h0, 0);
      check("d2b_redirect_wrap", redirect_pc, 32'h0);

      // Fill to capacity; push while full (even with a pop) is refused.
      for (int i = 0; i < DEPTH; i++) step(1, 32'h300 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
      check("d3_ready_full", 32'(enq_ready), 32'd0);
      check("d3_count_full", 32'(count), 32'd8);
      step(1, 32'h999, 0, 0, 0, 0, 0, 0);
      check("d3_count_9th", 32'(count), 32'd8);
      step(1, 32'h998, 0, 0, 1, 0, 0, 0);
      check("d3_ready_after_pop", 32'(enq_ready), 32'd1);
      check("d3_count_after_pop", 32'(count), 32'd7);
      check("d3_upd_pc", upd_pc, 32'h300);

      // Same-cycle push and pop keep the occupancy.
      step(1, 32'h500, 0, 0, 1, 0, 0, 0);
      check("d3b_count_same", 32'(count), 32'd7);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      check("d3b_flush_empty", 32'(count), 32'd0);

      // Resolve while empty: ignored but sticky error set.
      step(0, 0, 0, 0, 1, 1, 32'h40, 0);
      check("d4_upd_valid", 32'(upd_valid), 32'd0);
      check("d4_err", 32'(err_underflow), 32'd1);
      repeat (3) idle();
      check("d4_err_held", 32'(err_underflow), 32'd1);
      do_reset();

      // Flush with simultaneous resolve and enqueue at count 3.
      for (int i = 0; i < 3; i++) step(1, 32'h700 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
`ifdef BRQ_STATS_EN
      sb = stat_branches; sm = stat_mispredicts;
`endif
      step(1, 32'h800, 0, 0, 1, 1, 32'h44, 1);
      check("d5_count", 32'(count), 32'd0);
      check("d5_upd_valid", 32'(upd_valid), 32'd0);
      check("d5_mispredict", 32'(mispredict), 32'd0);
`ifdef BRQ_STATS_EN
      check("d5_stat_br", stat_branches, sb);
      check("d5_stat_mis", stat_mispredicts, sm);
`endif

      // Pointer wrap: 3 in flight, then 20 push+pop cycles, then drain.
      for (int i = 0; i < 3; i++) step(1, 32'h1000 + 32'(4 * i), 1, 32'h2000, 0, 0, 0, 0);
      for (int i = 0; i < 23; i++) begin
         exp_pc = 32'h1000 + 32'(4 * i);
         step(i < 20, 32'h1000 + 32'(4 * (i + 3)), 1, 32'h2000, 1, 1, 32'h2000, 0);
         check("d6_upd_pc", upd_pc, exp_pc);
      end
      check("d6_count_end", 32'(count), 32'd0);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         bit          ev, pt, rv, rt, fl;
         logic [31:0] pc, ptg, rtg;
         ev  = ($urandom_range(0, 9) < 6);
         pc  = $urandom & 32'hFFFF_FFFC;
         pt  = $urandom_range(0, 1) == 1;
         ptg = 32'($urandom_range(0, 7)) << 4;
         rv  = ($urandom_range(0, 9) < 5);
         fl  = ($urandom_range(0, 39) == 0);
         if (q.size() != 0 && $urandom_range(0, 4) != 0) begin
            rt  = q[0].taken;
            rtg = q[0].target;
         end else begin
            rt  = $urandom_range(0, 1) == 1;
            rtg = 32'($urandom_range(0, 7)) << 4;
         end
         step(ev, pc, pt, ptg, rv, rt, rtg, fl);
         if (c == 1500) begin
            // Asynchronous reset in the middle of a cycle.
            #2;
            do_reset();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
